// File: rtl/block_data_memory.sv
// Block-granular data memory: 64 x 32-bit blocks served to the data cache with a
// fixed LATENCY-cycle access, signalled through the busywait handshake.
module block_data_memory #(
    parameter int LATENCY = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic [1:0]  o_dbg_state
);

    // Handshake: read/write are level requests held until busywait is seen low;
    // busywait is high in IDLE while a request is present and throughout BUSY,
    // low in DONE, so the requester drops its request at the edge leaving DONE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_count;
    logic [5:0]  r_addr;
    logic [31:0] r_data;
    logic        r_is_write;
    logic [31:0] r_mem [64];
    logic        w_accept;
    logic        w_access;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busywait = read | write;
                if (read | write) begin
                    w_accept     = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                busywait = 1'b1;
                if (r_count == 4'd1) begin
                    w_access     = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        // Reset also suppresses the access so an aborted transfer leaves no trace.
        if (reset) begin
            busywait = 1'b0;
            w_access = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= 4'd0;
            readdata <= 32'd0;
        end else begin
            if (w_accept)               r_count <= LAT4;
            else if (r_state == S_BUSY) r_count <= r_count - 4'd1;
            if (w_access && !r_is_write) readdata <= r_mem[r_addr];
        end
    end

    // Request capture; inputs changing during BUSY are deliberately not observed.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_addr     <= address;
            r_data     <= writedata;
            r_is_write <= write;
        end
    end

    always_ff @(posedge clock) begin
        if (w_access && r_is_write) r_mem[r_addr] <= r_data;
    end

    assign o_dbg_state = r_state;

endmodule

// File: doc/block_data_memory.md
# block_data_memory

Block-granular data memory: the responder on the cache-to-memory interface, serving whole 32-bit blocks to the data cache's miss and write-back path. It holds 64 blocks of 4 bytes (256 bytes total), addressed by the 6-bit block address {tag, index}. Every access takes a fixed, parameterised number of cycles, signalled by a `busywait` handshake. The block sits below the data cache in the single-cycle processor's memory hierarchy and replaces any direct CPU-to-memory path.

## Interface
- `LATENCY`, default 5: number of cycles spent in BUSY per access; legal range 1..15.
- `clock`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  reset, synchronous, active-high; clock `clock`.
- `read`  in  1  block read request, level, held until `busywait` is seen low.
- `write`  in  1  block write request, level, held until `busywait` is seen low.
- `address`  in  6  block address.
- `writedata`  in  32  block to write; byte 0 is bits [7:0].
- `readdata`  out  32  block read; registered.
- `busywait`  out  1  high while a request is pending or in service.

## Operation
- Storage: 64 × 32-bit array. Contents are not affected by reset.
- FSM states:
  - IDLE:
    - At a posedge with `read` or `write` high: latch `address`, `writedata` and the operation (write wins if both are high), load the counter with `LATENCY`, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - Decrement the counter each posedge.
    - On the posedge where the counter is 1 (the LATENCY-th edge in BUSY), perform the access and go to DONE.
    - Write: array[latched address] <= latched data.
    - Read: `readdata` <= array[latched address].
  - DONE: go to IDLE on the next posedge unconditionally.
- `busywait` is combinational:
  - IDLE: `read` | `write`. It rises in the same cycle the request appears, so the requester never samples a false low.
  - BUSY: 1.
  - DONE: 0.
- `readdata` holds its value until the next read completes. Writes do not change it.
- Changes to `address`, `writedata`, `read` or `write` during BUSY are ignored. If the request drops during BUSY (a protocol violation), the access still completes.
- A request still high in IDLE after DONE is a new access. The requester must drop `read`/`write` at the posedge where it samples `busywait` low.
- Back-to-back: a write-back followed by a fill (`write` then `read`, different addresses) costs 2 × (LATENCY + 1) cycles, with one low-`busywait` cycle between the two accesses.

## Timing
- Reset, while `reset` is high at a posedge:
  - state = IDLE, counter = 0, `readdata` = 0.
  - `busywait` is forced to 0 while `reset` is high.
  - An access in progress is aborted: no array write, no `readdata` update.
- Edge numbering: E0 is the posedge that accepts the request.
- Access at E_LATENCY. DONE covers the cycle E_LATENCY..E_LATENCY+1. The requester samples `busywait` = 0 at E_LATENCY+1, and the FSM returns to IDLE at that same edge.
- `busywait` high span: from request assertion through E_LATENCY, i.e. LATENCY+1 cycles when the request is asserted right after an edge.
- `readdata` is valid from E_LATENCY. It is stable when the requester samples it at E_LATENCY+1.
- Counter width: 4 bits.

## Test plan
- Reset:
  - Assert `reset` for 2 cycles with `read` = 1 → `busywait` = 0 and `readdata` = 0x00000000.
  - Deassert `reset` → `busywait` = 1 immediately; the access is accepted at the next edge.
- Write then read, LATENCY = 5:
  - Write 0xDEADBEEF to address 0x2A → `busywait` high for exactly 6 cycles.
  - Read 0x2A → `readdata` = 0xDEADBEEF, valid at E5.
  - Reading 0x2B does not return 0xDEADBEEF.
- Write-back then fill: write 0x11223344 to 0x05, then read 0x25 (pre-loaded with 0xA5A5A5A5) → the second access is accepted one cycle after the first completes, `readdata` = 0xA5A5A5A5, total 12 cycles.
- Input change mid-access: write 0x00000001 to 0x10, and at E2 change to `address` = 0x11, `writedata` = 0xFFFFFFFF → read 0x10 returns 0x00000001, and 0x11 is unchanged.
- Reset mid-write: reset at E3 of a write of 0xCAFEF00D to 0x3F (pre-loaded with 0x0) → a subsequent read of 0x3F returns 0x00000000.
- Boundaries:
  - LATENCY = 1: `busywait` high for 2 cycles per access.
  - `read` and `write` both high → the write is performed and `readdata` is unchanged.
  - Address 0x00 and address 0x3F both read back correctly.
